btn_event_arbiter: RTL
======================

// Module: btn_event_arbiter
//
// PURPOSE
// - Collects one-cycle press/release pulses from NUM_BTNS debouncers and
//   serialises them into one ordered event stream for game/control logic.
// - Fair round-robin arbitration across buttons; small FIFO absorbs bursts.
// - Consumer pulls events with a valid/ready handshake. Lost events raise a
//   sticky overflow flag.
//
// PARAMETERS
// - NUM_BTNS    4  number of debounced buttons; must be >= 2
// - FIFO_DEPTH  8  event FIFO entries; must be a power of two, >= 2
// - IDX_W       $clog2(NUM_BTNS)  button index width (derived)
//
// PORTS
// - clk          in   1            system clock; all logic on posedge
// - rst_n        in   1            asynchronous, active-low reset
// - btn_down     in   NUM_BTNS     per-button press pulse, 1 cycle wide
// - btn_up       in   NUM_BTNS     per-button release pulse, 1 cycle wide
// - evt_valid    out  1            FIFO head holds a valid event
// - evt_ready    in   1            consumer accepts head when evt_valid=1
// - evt_btn      out  IDX_W        button index of head event
// - evt_is_up    out  1            1 = release, 0 = press
// - fifo_level   out  $clog2(FIFO_DEPTH)+1  occupied entries
// - overflow     out  1            sticky: an event was dropped
// - clr_overflow in   1            synchronous clear of overflow
//
// BEHAVIOUR
// - Reset (rst_n=0, async): pending bits, FIFO pointers, RR pointer and
//   overflow all 0. evt_valid=0, evt_btn=0, evt_is_up=0, fifo_level=0.
// - Request vector req[2*NUM_BTNS-1:0]: req[2*i]=press i, req[2*i+1]=release i.
// - Pending stage: a pulse on edge k sets pend[j]. If pend[j] is already set
//   and is not granted that cycle, the new pulse is dropped and overflow is
//   set. If pend[j] is granted in the same cycle as a new pulse, set wins:
//   pend[j] stays 1. One event is consumed and one stays pending.
// - Arbiter: combinational round-robin over pend, starting at rr_ptr.
//   - Grant is issued only when the FIFO is not full (registered full flag).
//   - A grant clears pend[g], writes {g[0], g>>1} into the FIFO and sets
//     rr_ptr <= (g+1) mod 2*NUM_BTNS.
//   - No grant: rr_ptr holds.
//   - At most one push per cycle.
// - Latency: pulse at edge k, push at edge k+1, evt_valid=1 after edge k+1
//   when the FIFO was empty. Total 2 cycles, pulse to visible event.
// - Handshake:
//   - Pop occurs on an edge where evt_valid & evt_ready.
//   - Head outputs are stable while evt_valid=1 and evt_ready=0.
//   - evt_ready with evt_valid=0 is ignored.
// - Full FIFO: no grants. Pending bits hold; they are not lost.
//   - A pop and a would-be push in the same cycle: the pop occurs; the push
//     waits 1 cycle.
//   - Empty + push: no bypass; head appears next cycle.
// - Pointers are $clog2(FIFO_DEPTH)+1 bits and wrap naturally.
//   - full  = MSBs differ, LSBs equal.
//   - empty = pointers equal.
// - overflow: set by a drop, cleared by clr_overflow. If both happen in the
//   same cycle, set wins.
// - Reset mid-operation: all queued and pending events are discarded.
//   Outputs return to reset values immediately (async).
//
// STRUCTURE
// - Shared package btn_evt_pkg:
//   - event encoding: bit order {is_up, btn_idx}
//   - request-index mapping: 2*i + is_up
//   - width functions
// - Sub-module btn_evt_fifo: sync FIFO, clk/rst_n, push/pop, data out,
//   full/empty/level. Instantiated once.
// - Top level holds: pending register, RR arbiter, overflow flag.
//
// TESTING
// - Reset: assert rst_n=0 mid-burst -> evt_valid=0, fifo_level=0 and
//   overflow=0 at once. No stale event after release.
// - Single press: btn_down[2] pulse at edge k -> evt_valid at k+2 with
//   evt_btn=2, evt_is_up=0. Pop -> fifo_level returns to 0.
// - Fairness: all btn_down and btn_up pulse together, evt_ready=1 ->
//   8 events in order (0,P)(0,R)(1,P)(1,R)...(3,R), each exactly once.
// - Backpressure/full: evt_ready=0, send 12 distinct events ->
//   fifo_level=8, 4 events held pending, overflow=0. Then evt_ready=1 ->
//   all 12 delivered.
// - Drop: btn_down[1] pulses twice while FIFO is full -> overflow=1, only
//   one (1,P) delivered. clr_overflow -> overflow=0.
// - Same-cycle set/grant: pulse btn_down[0] on the cycle pend[0] is
//   granted -> two (0,P) events delivered, overflow=0.

Source files
------------

// File: rtl/btn_evt_pkg.sv
// Shared definitions for the button event arbiter: event kinds, request
// index mapping and derived widths.
package btn_evt_pkg;

  typedef enum logic {
    EVT_PRESS   = 1'b0,
    EVT_RELEASE = 1'b1
  } evt_kind_e;

  // Button index width; never zero so single-bit buses stay legal.
  function automatic int idx_w(input int num_btns);
    return (num_btns < 2) ? 1 : $clog2(num_btns);
  endfunction

  function automatic int lvl_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

  // Request slot for a button edge: presses on even slots, releases on odd.
  function automatic int req_idx(input int btn, input evt_kind_e kind);
    return 2 * btn + int'(kind);
  endfunction

endpackage

// File: rtl/btn_evt_if.sv
// Bundle of button pulse inputs and the event stream handshake.
// Handshake: a pop happens on a posedge where evt_valid && evt_ready; while
// evt_valid=1 and evt_ready=0 the head (evt_btn, evt_is_up) holds steady;
// evt_ready is ignored while evt_valid=0.
interface btn_evt_if
  import btn_evt_pkg::*;
#(
  parameter int NUM_BTNS   = 4,
  parameter int FIFO_DEPTH = 8
);
  localparam int IDX_W = idx_w(NUM_BTNS);
  localparam int LVL_W = lvl_w(FIFO_DEPTH);

  logic [NUM_BTNS-1:0] btn_down;
  logic [NUM_BTNS-1:0] btn_up;
  logic                evt_valid;
  logic                evt_ready;
  logic [IDX_W-1:0]    evt_btn;
  logic                evt_is_up;
  logic [LVL_W-1:0]    fifo_level;
  logic                overflow;
  logic                clr_overflow;

  modport master (
    output btn_down, btn_up, evt_ready, clr_overflow,
    input  evt_valid, evt_btn, evt_is_up, fifo_level, overflow
  );

  modport slave (
    input  btn_down, btn_up, evt_ready, clr_overflow,
    output evt_valid, evt_btn, evt_is_up, fifo_level, overflow
  );

endinterface

// File: rtl/btn_evt_fifo.sv
// Synchronous FIFO with one-extra-bit pointers; full/empty derived from the
// registered pointers, no write-to-read bypass.
module btn_evt_fifo #(
  parameter int DEPTH = 8,
  parameter int W     = 3
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  logic [W-1:0]           push_data,
  input  logic                   pop,
  output logic [W-1:0]           pop_data,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] level
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] mem [DEPTH];
  logic [AW:0]  wr_ptr;
  logic [AW:0]  rd_ptr;
  logic         do_push;
  logic         do_pop;

  assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign empty    = (wr_ptr == rd_ptr);
  assign level    = wr_ptr - rd_ptr;
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign pop_data = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Storage needs no reset: it is only observed through non-empty pointers.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/btn_event_arbiter.sv
// Serialises per-button press/release pulses into one event stream through
// a pending register, a round-robin arbiter and a small FIFO.
module btn_event_arbiter
  import btn_evt_pkg::*;
#(
  parameter int NUM_BTNS   = 4,
  parameter int FIFO_DEPTH = 8
) (
  input logic     clk,
  input logic     rst_n,
  btn_evt_if.slave bus
);
  localparam int IDX_W = idx_w(NUM_BTNS);
  localparam int REQ_N = 2 * NUM_BTNS;
  localparam int RW    = IDX_W + 1;
  localparam int EVT_W = IDX_W + 1;
  localparam int LVL_W = lvl_w(FIFO_DEPTH);

  logic [REQ_N-1:0] req;
  logic [REQ_N-1:0] pend;
  logic [REQ_N-1:0] gnt_oh;
  logic [REQ_N-1:0] drop;
  logic             gnt_vld;
  logic [RW-1:0]    gnt_idx;
  logic [RW-1:0]    rr_ptr;
  logic [RW:0]      scan_idx;
  logic             ovf_q;
  logic             fifo_full;
  logic             fifo_empty;
  logic [EVT_W-1:0] push_data;
  logic [EVT_W-1:0] head;
  logic [LVL_W-1:0] level;

  always_comb begin
    req = '0;
    for (int i = 0; i < NUM_BTNS; i++) begin
      req[req_idx(i, EVT_PRESS)]   = bus.btn_down[i];
      req[req_idx(i, EVT_RELEASE)] = bus.btn_up[i];
    end
  end

  // Scan pending slots starting at rr_ptr; first hit wins when FIFO has room.
  always_comb begin
    gnt_vld  = 1'b0;
    gnt_idx  = '0;
    scan_idx = '0;
    for (int k = 0; k < REQ_N; k++) begin
      scan_idx = {1'b0, rr_ptr} + (RW+1)'(k);
      if (scan_idx >= (RW+1)'(REQ_N)) scan_idx = scan_idx - (RW+1)'(REQ_N);
      if (!gnt_vld && !fifo_full && pend[scan_idx[RW-1:0]]) begin
        gnt_vld = 1'b1;
        gnt_idx = scan_idx[RW-1:0];
      end
    end
  end

  assign gnt_oh    = gnt_vld ? (REQ_N'(1) << gnt_idx) : '0;
  assign drop      = req & pend & ~gnt_oh;
  assign push_data = {gnt_idx[0], gnt_idx[RW-1:1]};

  // A new pulse on a slot being granted this cycle re-arms it (set wins).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend   <= '0;
      rr_ptr <= '0;
      ovf_q  <= 1'b0;
    end else begin
      pend <= (pend & ~gnt_oh) | req;
      if (gnt_vld) rr_ptr <= (gnt_idx == RW'(REQ_N - 1)) ? '0 : gnt_idx + RW'(1);
      if (|drop)                 ovf_q <= 1'b1;
      else if (bus.clr_overflow) ovf_q <= 1'b0;
    end
  end

  btn_evt_fifo #(
    .DEPTH (FIFO_DEPTH),
    .W     (EVT_W)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (gnt_vld),
    .push_data (push_data),
    .pop       (bus.evt_ready),
    .pop_data  (head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .level     (level)
  );

  // Head is masked while empty so idle outputs read as zero.
  assign bus.evt_valid  = !fifo_empty;
  assign bus.evt_btn    = fifo_empty ? '0 : head[IDX_W-1:0];
  assign bus.evt_is_up  = !fifo_empty && head[IDX_W];
  assign bus.fifo_level = level;
  assign bus.overflow   = ovf_q;

endmodule
